// File: rtl/game_player.sv
// game_player: initiator-side driver for a game-state block. Accepts a
// command (seed, counter mode), loads it into the game-state instance,
// watches the game until it ends, times out or is aborted, and returns
// a result record over a valid/ready handshake.
module game_player #(
  parameter int unsigned COUNTER_SIZE = 4,
  parameter int unsigned MAX_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [COUNTER_SIZE-1:0] cmd_seed,
  input  logic [1:0]              cmd_mode,
  input  logic                    abort,
  // towards game-state
  output logic                    INIT,
  output logic [COUNTER_SIZE-1:0] i_value,
  output logic [1:0]              control,
  // from game-state
  input  logic                    win,
  input  logic                    los,
  input  logic                    gameover,
  input  logic [1:0]              who,
  // result channel
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_who,
  output logic                    res_timeout,
  output logic [4:0]              res_wins,
  output logic [4:0]              res_losses,
  output logic [15:0]             res_cycles,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] BUDGET  = 16'(MAX_CYCLES);
  localparam logic [4:0]  TALLY_MAX = 5'd31;

  state_t      state;
  state_t      state_next;
  logic        cmd_accept;
  logic        budget_hit;
  logic [15:0] cycles_inc;

  // Handshake decodes come straight off the state register; reset masks
  // them so nothing is offered while reset is held.
  assign cmd_ready = (state == S_IDLE) && !reset;
  assign busy      = ((state == S_LOAD) || (state == S_RUN)) && !reset;

  // Next-state logic; RUN exits in priority order abort, gameover, budget.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    cmd_accept = 1'b0;
    cycles_inc = res_cycles + 16'd1;
    budget_hit = (cycles_inc == BUDGET);
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_accept = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
        if (abort)           state_next = S_IDLE;
        else if (gameover)   state_next = S_DONE;
        else if (budget_hit) state_next = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Registered outputs: load interface, tallies and result record.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a control/result flop, so all of them
    // take the reset value; there is no storage array to leave unreset.
    if (reset) begin
      INIT        <= 1'b0;
      i_value     <= '0;
      control     <= 2'b00;
      res_valid   <= 1'b0;
      res_who     <= 2'b00;
      res_timeout <= 1'b0;
      res_wins    <= '0;
      res_losses  <= '0;
      res_cycles  <= '0;
    end else begin
      // INIT is high exactly for the LOAD cycle that follows an accept.
      INIT      <= cmd_accept;
      res_valid <= (state_next == S_DONE);

      if (cmd_accept) begin
        i_value     <= cmd_seed;
        control     <= cmd_mode;
        res_who     <= 2'b00;
        res_timeout <= 1'b0;
        res_wins    <= '0;
        res_losses  <= '0;
        res_cycles  <= '0;
      end

      if (state == S_RUN) begin
        // The terminating cycle is counted like any other RUN cycle.
        res_cycles <= cycles_inc;
        if (win && (res_wins != TALLY_MAX))   res_wins   <= res_wins + 5'd1;
        if (los && (res_losses != TALLY_MAX)) res_losses <= res_losses + 5'd1;
        if (!abort) begin
          if (gameover) begin
            // who is captured raw, including the 00/11 codes.
            res_who     <= who;
            res_timeout <= 1'b0;
          end else if (budget_hit) begin
            res_who     <= 2'b00;
            res_timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_game_player.sv
// Self-checking bench for game_player: directed scenarios plus randomized
// games, each checked against a per-game reference model of the rules.
module tb_game_player;

  localparam int CS  = 4;
  localparam int MAX = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CS-1:0] cmd_seed;
  logic [1:0]    cmd_mode;
  logic          abort;
  logic          INIT;
  logic [CS-1:0] i_value;
  logic [1:0]    control;
  logic          win;
  logic          los;
  logic          gameover;
  logic [1:0]    who;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_who;
  logic          res_timeout;
  logic [4:0]    res_wins;
  logic [4:0]    res_losses;
  logic [15:0]   res_cycles;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  // Per-RUN-cycle stimulus, indexed by RUN cycle number starting at 1.
  bit       sw   [0:255];
  bit       sl   [0:255];
  bit       sg   [0:255];
  bit       sa   [0:255];
  bit [1:0] swho [0:255];

  game_player #(.COUNTER_SIZE(CS), .MAX_CYCLES(MAX)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_seed(cmd_seed), .cmd_mode(cmd_mode), .abort(abort),
    .INIT(INIT), .i_value(i_value), .control(control),
    .win(win), .los(los), .gameover(gameover), .who(who),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_who(res_who), .res_timeout(res_timeout),
    .res_wins(res_wins), .res_losses(res_losses),
    .res_cycles(res_cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_seq();
    for (int c = 0; c < 256; c++) begin
      sw[c] = 1'b0; sl[c] = 1'b0; sg[c] = 1'b0; sa[c] = 1'b0; swho[c] = 2'b00;
    end
  endtask

  // Reference: walk the game cycle by cycle by the rules of the block.
  function automatic void model(output bit ab, output bit [1:0] rwho, output bit to,
                                output int w, output int l, output int cyc);
    ab = 0; rwho = 2'b00; to = 0; w = 0; l = 0; cyc = 0;
    for (int c = 1; c <= MAX; c++) begin
      cyc = c;
      if (sw[c] && w < 31) w++;
      if (sl[c] && l < 31) l++;
      if (sa[c]) begin ab = 1; return; end
      if (sg[c]) begin rwho = swho[c]; return; end
      if (c == MAX) begin to = 1; return; end
    end
  endfunction

  // Runs one game from an idle DUT at a negedge; returns at a negedge
  // with the DUT idle again.
  task automatic run_game(input logic [CS-1:0] seed, input logic [1:0] mode,
                          input int hold, input bit keep_valid);
    bit e_ab, e_to;
    bit [1:0] e_who;
    int e_w, e_l, e_cyc;
    logic [63:0] e_res;
    model(e_ab, e_who, e_to, e_w, e_l, e_cyc);
    e_res = {35'd0, e_who, e_to, 5'(e_w), 5'(e_l), 16'(e_cyc)};

    cmd_valid = 1'b1; cmd_seed = seed; cmd_mode = mode;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    if (!keep_valid) cmd_valid = 1'b0;
    // New command values and game-state flags must be ignored in LOAD.
    cmd_seed = CS'($urandom_range(0, 15)); cmd_mode = 2'($urandom_range(0, 3));
    win = 1'($urandom_range(0, 1)); los = 1'($urandom_range(0, 1));
    gameover = 1'($urandom_range(0, 1)); who = 2'($urandom_range(0, 3));
    #1;
    check("load_init", INIT, 1);
    check("load_value_mode", {i_value, control}, {seed, mode});
    check("load_busy_ready", {busy, cmd_ready, res_valid}, 3'b100);
    @(negedge clk);
    for (int c = 1; c <= e_cyc; c++) begin
      win = sw[c]; los = sl[c]; gameover = sg[c]; who = swho[c]; abort = sa[c];
      res_ready = 1'($urandom_range(0, 1));
      #1;
      if (c == 1) check("run_init_low", INIT, 0);
      check("run_flags", {busy, cmd_ready, res_valid}, 3'b100);
      check("run_value_mode", {i_value, control}, {seed, mode});
      @(negedge clk);
    end
    win = 0; los = 0; gameover = 0; who = 0; abort = 0; res_ready = 0;
    #1;
    if (e_ab) begin
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check("abort_no_result", {res_valid, busy, cmd_ready}, 3'b001);
        @(negedge clk);
      end
    end else begin
      check("done_valid", {res_valid, busy, cmd_ready, INIT}, 4'b1000);
      check("done_record", {35'd0, res_who, res_timeout, res_wins, res_losses, res_cycles}, e_res);
      check("done_mode", control, mode);
      for (int k = 0; k < hold; k++) begin
        abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        check("hold_valid", {res_valid, cmd_ready}, 2'b10);
        check("hold_record", {35'd0, res_who, res_timeout, res_wins, res_losses, res_cycles}, e_res);
      end
      abort = 0; res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; cmd_valid = 1'b0;
      #1 check("after_handshake", {res_valid, busy, cmd_ready}, 3'b001);
    end
  endtask

  task automatic gen_random();
    int go_at;
    int ab_at;
    clear_seq();
    go_at = $urandom_range(1, MAX + 10);
    ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAX) : 0;
    for (int c = 1; c < 256; c++) begin
      sw[c]   = ($urandom_range(0, 3) == 0);
      sl[c]   = ($urandom_range(0, 3) == 0);
      swho[c] = 2'($urandom_range(0, 3));
    end
    if (go_at <= MAX) sg[go_at] = 1'b1;
    if (ab_at != 0)   sa[ab_at] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b1; cmd_seed = 4'hA; cmd_mode = 2'b10;
    abort = 0; win = 0; los = 0; gameover = 0; who = 0; res_ready = 0;

    // Reset held 3 cycles with a command offered: nothing accepted.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("reset_outputs",
               {INIT, i_value, control, res_valid, res_who, res_timeout,
                res_wins, res_losses, res_cycles, busy, cmd_ready}, 64'd0);
    end
    reset = 1'b0; cmd_valid = 1'b0;
    #1 check("reset_release_ready", {cmd_ready, busy}, 2'b10);
    @(negedge clk);
    #1 check("idle_after_reset", {cmd_ready, busy, INIT, res_valid}, 4'b1000);

    // Basic game: 3 wins, 2 losses, winner on RUN cycle 40.
    clear_seq();
    sw[3] = 1; sw[10] = 1; sw[20] = 1; sl[5] = 1; sl[30] = 1;
    sg[40] = 1; swho[40] = 2'b10;
    run_game(4'd5, 2'b01, 2, 1'b0);

    // Timeout with the result held off for 5 cycles.
    clear_seq();
    sw[2] = 1; sl[7] = 1;
    run_game(4'd12, 2'b11, 5, 1'b0);

    // gameover and abort together: abort wins, no result.
    clear_seq();
    sg[6] = 1; swho[6] = 2'b01; sa[6] = 1;
    run_game(4'd3, 2'b10, 0, 1'b0);

    // gameover on the last budget cycle beats the timeout.
    clear_seq();
    sg[MAX] = 1; swho[MAX] = 2'b01;
    run_game(4'd0, 2'b00, 1, 1'b0);

    // Minimum latency: gameover on the first RUN cycle, raw who=11.
    clear_seq();
    sg[1] = 1; swho[1] = 2'b11; sw[1] = 1;
    run_game(4'd15, 2'b01, 0, 1'b0);

    // Saturation with a command held valid through the whole game,
    // then a back-to-back game.
    clear_seq();
    for (int c = 1; c <= 40; c++) begin sl[c] = 1; sw[c] = 1; end
    sg[45] = 1; swho[45] = 2'b10;
    run_game(4'd7, 2'b10, 2, 1'b1);
    gen_random();
    run_game(4'd8, 2'b01, 1, 1'b0);

    // Mid-run reset on RUN cycle 7.
    clear_seq();
    cmd_valid = 1'b1; cmd_seed = 4'd9; cmd_mode = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) @(negedge clk);
    #1 check("midrun_busy_cycles", {busy, res_cycles}, {1'b1, 16'd6});
    reset = 1'b1;
    #1 check("midrun_ready_in_reset", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("midrun_after_reset",
             {INIT, control, i_value, res_valid, busy, cmd_ready}, {1'b0, 2'b00, 4'd0, 3'b001});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("midrun_no_result", res_valid, 0);
    end
    gen_random();
    sa[1] = 0;
    run_game(4'd9, 2'b11, 1, 1'b0);

    // Randomized games.
    for (int g = 0; g < 20; g++) begin
      gen_random();
      run_game(CS'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
